// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I issue stage in front of the ALU.
// Decodes one instruction per cycle into ALU control plus selected operands,
// presents it from a registered output slot with valid/ready, and uses a
// one-entry skid buffer so that backpressure never drops an instruction.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int CTR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTR_W-1:0]  out_ctr,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [4:0]        out_rd,
    output logic              out_wen,
    output logic              out_is_branch,
    output logic              out_is_store,
    output logic [DATA_W-1:0] out_store_data,
    output logic              out_illegal
);

    localparam logic [CTR_W-1:0] CTR_AND = CTR_W'(4'b0000);
    localparam logic [CTR_W-1:0] CTR_OR  = CTR_W'(4'b0001);
    localparam logic [CTR_W-1:0] CTR_ADD = CTR_W'(4'b0010);
    localparam logic [CTR_W-1:0] CTR_SUB = CTR_W'(4'b0110);

    typedef enum logic [6:0] {
        OPC_R      = 7'b0110011,
        OPC_I      = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    // One fully decoded operation, as held in the main slot or the skid entry.
    typedef struct packed {
        logic [CTR_W-1:0]  ctr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [4:0]        rd;
        logic              wen;
        logic              is_branch;
        logic              is_store;
        logic [DATA_W-1:0] store_data;
        logic              illegal;
    } op_t;

    // Instruction fields
    opcode_e           opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd_field;
    logic signed [11:0] imm_i12;
    logic signed [11:0] imm_s12;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_s;
    // rs1/rs2 index fields are resolved by the register file upstream.
    logic              unused_rs1_field;

    assign opcode           = opcode_e'(instr[6:0]);
    assign funct3           = instr[14:12];
    assign funct7           = instr[31:25];
    assign rd_field         = instr[11:7];
    assign imm_i12          = instr[31:20];
    assign imm_s12          = {instr[31:25], instr[11:7]};
    assign imm_i            = DATA_W'(imm_i12);
    assign imm_s            = DATA_W'(imm_s12);
    assign unused_rs1_field = ^instr[19:15];

    // ADD/OR/AND selection shared by R-type and I-type arithmetic.
    function automatic logic [CTR_W-1:0] ctr_from_f3(input logic [2:0] f3);
        case (f3)
            3'b110:  ctr_from_f3 = CTR_OR;
            3'b111:  ctr_from_f3 = CTR_AND;
            default: ctr_from_f3 = CTR_ADD;
        endcase
    endfunction

    op_t dec;

    // Decode the offered instruction; anything unlisted falls out as illegal.
    always_comb begin
        // NOTE: every field gets a default before the case so no latch is inferred.
        dec         = '0;
        dec.ctr     = CTR_ADD;
        dec.illegal = 1'b1;
        case (opcode)
            OPC_R: begin
                if ((funct7 == 7'b0000000 &&
                     (funct3 == 3'b000 || funct3 == 3'b110 || funct3 == 3'b111)) ||
                    (funct7 == 7'b0100000 && funct3 == 3'b000)) begin
                    dec     = '0;
                    dec.ctr = funct7[5] ? CTR_SUB : ctr_from_f3(funct3);
                    dec.a   = rs1_data;
                    dec.b   = rs2_data;
                    dec.rd  = rd_field;
                    dec.wen = (rd_field != 5'd0);
                end
            end
            OPC_I: begin
                if (funct3 == 3'b000 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    dec     = '0;
                    dec.ctr = ctr_from_f3(funct3);
                    dec.a   = rs1_data;
                    dec.b   = imm_i;
                    dec.rd  = rd_field;
                    dec.wen = (rd_field != 5'd0);
                end
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    dec     = '0;
                    dec.ctr = CTR_ADD;
                    dec.a   = rs1_data;
                    dec.b   = imm_i;
                    dec.rd  = rd_field;
                    dec.wen = (rd_field != 5'd0);
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) begin
                    dec            = '0;
                    dec.ctr        = CTR_ADD;
                    dec.a          = rs1_data;
                    dec.b          = imm_s;
                    dec.store_data = rs2_data;
                    dec.is_store   = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    dec           = '0;
                    dec.ctr       = CTR_SUB;
                    dec.a         = rs1_data;
                    dec.b         = rs2_data;
                    dec.is_branch = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Storage: main output slot plus one skid entry.
    op_t  main_q, main_d;
    op_t  skid_q, skid_d;
    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic accept;
    logic drain;

    // in_ready depends only on held state, never on out_ready.
    assign in_ready = !skid_valid_q && !rst;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid_q && out_ready;

    // Next-state for main/skid: skid refills main first to keep FIFO order.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain || !main_valid_q) begin
            // accept implies an empty skid, so these branches are exclusive.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the data payloads are reset too, so every output reads 0 after reset.
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid      = main_valid_q;
    assign out_ctr        = main_q.ctr;
    assign out_a          = main_q.a;
    assign out_b          = main_q.b;
    assign out_rd         = main_q.rd;
    assign out_wen        = main_q.wen;
    assign out_is_branch  = main_q.is_branch;
    assign out_is_store   = main_q.is_store;
    assign out_store_data = main_q.store_data;
    assign out_illegal    = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: the driver pushes hand-computed
// expectations on accept, a monitor pops and compares on every handshake.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_ctr;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_is_branch;
    logic        out_is_store;
    logic [31:0] out_store_data;
    logic        out_illegal;

    alu_issue_stage #(.DATA_W(32), .CTR_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ctr       (out_ctr),
        .out_a         (out_a),
        .out_b         (out_b),
        .out_rd        (out_rd),
        .out_wen       (out_wen),
        .out_is_branch (out_is_branch),
        .out_is_store  (out_is_store),
        .out_store_data(out_store_data),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctr;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wen;
        logic        br;
        logic        st;
        logic [31:0] sd;
        logic        ill;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    int   pop_cyc[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic wen, input logic br,
                                input logic st, input logic [31:0] sd, input logic ill);
        exp_t e;
        e.ctr = ctr; e.a = a; e.b = b; e.rd = rd; e.wen = wen;
        e.br = br; e.st = st; e.sd = sd; e.ill = ill;
        return e;
    endfunction

    // Monitor: compare every completed output handshake against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    pop_cyc.push_back(cyc);
                    check("ctr",        {28'b0, out_ctr},       {28'b0, e.ctr});
                    check("a",          out_a,                  e.a);
                    check("b",          out_b,                  e.b);
                    check("rd",         {27'b0, out_rd},        {27'b0, e.rd});
                    check("wen",        {31'b0, out_wen},       {31'b0, e.wen});
                    check("is_branch",  {31'b0, out_is_branch}, {31'b0, e.br});
                    check("is_store",   {31'b0, out_is_store},  {31'b0, e.st});
                    check("store_data", out_store_data,         e.sd);
                    check("illegal",    {31'b0, out_illegal},   {31'b0, e.ill});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction until accepted (bounded); push its expectation on accept.
    task automatic send(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                        input exp_t e);
        in_valid = 1'b1; instr = i; rs1_data = r1; rs2_data = r2;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        check("send_timeout", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctr"},   {28'b0, out_ctr}, 32'd0);
        check({tag, "_a"},     out_a,            32'd0);
        check({tag, "_b"},     out_b,            32'd0);
        check({tag, "_rd"},    {27'b0, out_rd},  32'd0);
        check({tag, "_sd"},    out_store_data,   32'd0);
        check({tag, "_flags"}, {28'b0, out_wen, out_is_branch, out_is_store, out_illegal}, 32'd0);
    endtask

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;

    localparam logic [31:0] I_ADD_X3 = 32'h002081B3;

    initial begin
        int          n;
        int          acc;
        int          idx;
        logic [31:0] snap_a, snap_b;
        logic [3:0]  snap_ctr;
        logic [31:0] bp_r1 [3];
        logic [31:0] bp_r2 [3];
        bp_r1 = '{32'd10, 32'd20, 32'd30};
        bp_r2 = '{32'd1,  32'd2,  32'd3};

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        instr = '0; rs1_data = '0; rs2_data = '0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready},  32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_outputs_zero("post_rst");
        tick();

        // Back-to-back ADD then SUB with no bubble
        out_ready = 1'b1;
        n = pop_cyc.size();
        send(I_ADD_X3,     32'd5, 32'd7, mk(C_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));
        send(32'h402081B3, 32'd5, 32'd7, mk(C_SUB, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));
        for (int k = 0; k < 10 && pop_cyc.size() < n + 2; k++) tick();
        check("stream_pops", pop_cyc.size(), n + 2);
        if (pop_cyc.size() >= n + 2)
            check("stream_no_bubble", pop_cyc[n+1] - pop_cyc[n], 32'd1);

        // Assorted legal encodings
        send(32'hFFF00293, 32'd0, 32'h55,
             mk(C_ADD, 32'd0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));          // ADDI x5,x0,-1
        send(32'h0020A423, 32'h100, 32'hAB,
             mk(C_ADD, 32'h100, 32'd8, 5'd0, 1'b0, 1'b0, 1'b1, 32'hAB, 1'b0));              // SW x2,8(x1)
        send(32'h0FF0F313, 32'h1234, 32'h9,
             mk(C_AND, 32'h1234, 32'hFF, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));             // ANDI x6,x1,0xFF
        send(32'h0020E1B3, 32'hF0, 32'h0F,
             mk(C_OR, 32'hF0, 32'h0F, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));                // OR x3,x1,x2
        send(32'hFFC12383, 32'h1000, 32'h77,
             mk(C_ADD, 32'h1000, 32'hFFFFFFFC, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));       // LW x7,-4(x2)
        send(32'h00208063, 32'd9, 32'd9,
             mk(C_SUB, 32'd9, 32'd9, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0));                 // BEQ x1,x2

        // Illegal and boundary encodings
        send(32'h0000007F, 32'h11, 32'h22,
             mk(C_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1));                 // bad opcode
        send(32'h00208033, 32'd3, 32'd4,
             mk(C_ADD, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));                 // ADD x0,x1,x2
        send(32'h0020C063, 32'd1, 32'd2,
             mk(C_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1));                 // branch f3=100
        send(32'h022081B3, 32'd6, 32'd7,
             mk(C_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1));                 // f7=0000001
        drain();

        // Backpressure: three offered, exactly two absorbed
        out_ready = 1'b0;
        idx = 0; acc = 0;
        for (int c = 0; c < 4; c++) begin
            if (idx < 3) begin
                in_valid = 1'b1; instr = I_ADD_X3; rs1_data = bp_r1[idx]; rs2_data = bp_r2[idx];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(mk(C_ADD, bp_r1[idx], bp_r2[idx], 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));
                acc++; idx++;
            end
            tick();
        end
        @(negedge clk);
        check("bp_accepted", acc, 32'd2);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        snap_a = out_a; snap_b = out_b; snap_ctr = out_ctr;
        tick(); tick();
        @(negedge clk);
        check("bp_stable_a",   out_a, snap_a);
        check("bp_stable_b",   out_b, snap_b);
        check("bp_stable_ctr", {28'b0, out_ctr}, {28'b0, snap_ctr});
        check("bp_stable_a_val", out_a, 32'd10);
        tick();

        // Release and let the third instruction in
        out_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            in_valid = 1'b1; instr = I_ADD_X3; rs1_data = bp_r1[idx]; rs2_data = bp_r2[idx];
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(mk(C_ADD, bp_r1[idx], bp_r2[idx], 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));
                idx++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("bp_third_accepted", idx, 32'd3);
        drain();
        @(negedge clk);
        check("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
        tick();

        // Flush with both entries full and a new input offered
        out_ready = 1'b0;
        send(32'h002081B3, 32'hDEAD, 32'h1, mk(C_ADD, 32'hDEAD, 32'h1, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));
        send(32'h402081B3, 32'hBEEF, 32'h2, mk(C_SUB, 32'hBEEF, 32'h2, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));
        @(negedge clk);
        check("fl_full", {31'b0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b1; instr = 32'h0020E1B3; rs1_data = 32'h3; rs2_data = 32'h4;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("fl_out_valid", {31'b0, out_valid}, 32'd0);
        check("fl_in_ready",  {31'b0, in_ready},  32'd1);
        tick();
        out_ready = 1'b1;
        repeat (5) tick();

        // Same setup, cleared by reset instead
        out_ready = 1'b0;
        send(32'h002081B3, 32'hCAFE, 32'h5, mk(C_ADD, 32'hCAFE, 32'h5, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));
        send(32'h0020A423, 32'h200, 32'h6, mk(C_ADD, 32'h200, 32'd8, 5'd0, 1'b0, 1'b0, 1'b1, 32'h6, 1'b0));
        tick();
        in_valid = 1'b1; instr = 32'h0020E1B3; rs1_data = 32'h3; rs2_data = 32'h4;
        rst = 1'b1;
        @(negedge clk);
        check("rs_in_ready_during", {31'b0, in_ready}, 32'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rs_out_valid", {31'b0, out_valid}, 32'd0);
        check("rs_in_ready",  {31'b0, in_ready},  32'd1);
        check_outputs_zero("rs");
        tick();
        out_ready = 1'b1;
        repeat (5) tick();

        // A final op after reset still flows normally
        send(32'hFFF00293, 32'd0, 32'd0,
             mk(C_ADD, 32'd0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
